// File: rtl/dram_pattern_tester.sv
// DDR3 pattern test engine: writes a selectable pattern over a beat range,
// reads it back, compares each beat and reports errors / read timeout.
// Grants controller refresh between requests.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; result outputs hold
// S_INIT  | waiting for the DDR3 controller to finish initialisation
// S_WR    | issuing write beats 0..N-1
// S_RD    | issuing one read request
// S_RWAIT | waiting for read data (bounded by TIMEOUT), then compare
// S_REF   | refresh granted; wait for refresh_req to drop
// S_DONE  | one-cycle done pulse, back to idle
module dram_pattern_tester #(
   parameter int          ADDR_W    = 27,
   parameter int          DATA_W    = 128,
   parameter int          BEAT_W    = 24,
   parameter int          ERR_W     = 16,
   parameter logic [31:0] LFSR_SEED = 32'hACE1_2025,
   parameter int          TIMEOUT   = 1024
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  sdram_init_busy,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     cfg_base,
   input  logic [BEAT_W-1:0]     cfg_beats,
   input  logic [1:0]            cfg_mode,
   output logic                  busy,
   output logic                  done,
   output logic [ERR_W-1:0]      error_count,
   output logic [ADDR_W-1:0]     first_err_addr,
   output logic                  err_flag,
   output logic                  timeout_flag,
   input  logic                  refresh_req,
   output logic                  refresh_ack,
   output logic [ADDR_W-1:0]     dram_address,
   output logic                  dram_write,
   output logic                  dram_valid,
   input  logic                  dram_ready,
   output logic [DATA_W-1:0]     dram_wdata,
   output logic [DATA_W/8-1:0]   dram_wdata_mask,
   input  logic [DATA_W-1:0]     dram_rdata,
   input  logic                  dram_rdata_valid
);

   localparam int LANES = DATA_W / 32;
   localparam int STEP  = DATA_W / 16;
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_WR, S_RD, S_RWAIT, S_REF, S_DONE
   } state_t;

   // Galois LFSR, taps x^32+x^22+x^2+x+1, shifting towards bit 0
   function automatic logic [31:0] lfsr_next(input logic [31:0] v);
      return {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   function automatic logic [DATA_W-1:0] pattern(input logic [1:0] mode,
                                                 input logic [BEAT_W-1:0] idx,
                                                 input logic [31:0] lfsr);
      logic [DATA_W-1:0] p;
      logic [31:0]       i32;
      logic [31:0]       sum;
      p   = '0;
      i32 = 32'(idx);
      for (int j = 0; j < LANES; j++) begin
         sum = i32 + 32'(j);
         case (mode)
            2'd0:    p[j*32 +: 32] = sum;
            2'd1:    p[j*32 +: 32] = ~sum;
            2'd3:    p[j*32 +: 32] = (lfsr << j) | (lfsr >> (32 - j));
            default: ;
         endcase
      end
      if (mode == 2'd2)
         p = {{(DATA_W-1){1'b0}}, 1'b1} << (i32 % 32'(DATA_W));
      return p;
   endfunction

   state_t             r_state, r_ret_state;
   logic [ADDR_W-1:0]  r_base, r_addr, r_first_err;
   logic [BEAT_W-1:0]  r_beats, r_idx;
   logic [1:0]         r_mode;
   logic [31:0]        r_lfsr;
   logic [TMR_W-1:0]   r_tmr;
   logic [ERR_W-1:0]   r_err_cnt;
   logic [DATA_W-1:0]  r_wdata;
   logic               r_valid, r_write, r_busy, r_done, r_err_flag, r_timeout, r_ref_ack;

   logic [DATA_W-1:0]  w_pattern;
   logic               w_last;
   logic [ADDR_W-1:0]  w_next_addr;

   assign w_pattern   = pattern(r_mode, r_idx, r_lfsr);
   assign w_last      = (r_idx == r_beats - BEAT_W'(1));
   assign w_next_addr = r_addr + ADDR_W'(STEP);

   // Sequencer: all request, status and result outputs are registered here
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_ret_state <= S_IDLE;
         r_base      <= '0;
         r_addr      <= '0;
         r_first_err <= '0;
         r_beats     <= '0;
         r_idx       <= '0;
         r_mode      <= '0;
         r_lfsr      <= '0;
         r_tmr       <= '0;
         r_err_cnt   <= '0;
         r_wdata     <= '0;
         r_valid     <= 1'b0;
         r_write     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err_flag  <= 1'b0;
         r_timeout   <= 1'b0;
         r_ref_ack   <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_ref_ack <= 1'b0;
         case (r_state)
            S_IDLE: if (start) begin
               r_base      <= cfg_base;
               r_beats     <= cfg_beats;
               r_mode      <= cfg_mode;
               r_idx       <= '0;
               r_addr      <= cfg_base;
               r_lfsr      <= LFSR_SEED;
               r_err_cnt   <= '0;
               r_first_err <= '0;
               r_err_flag  <= 1'b0;
               r_timeout   <= 1'b0;
               r_busy      <= 1'b1;
               r_state     <= (cfg_beats == '0) ? S_DONE : S_INIT;
            end
            S_INIT: if (!sdram_init_busy) r_state <= S_WR;
            S_WR: begin
               if (r_valid) begin
                  if (dram_ready) begin
                     r_valid <= 1'b0;
                     if (w_last) begin
                        r_idx   <= '0;
                        r_addr  <= r_base;
                        r_lfsr  <= LFSR_SEED;
                        r_state <= S_RD;
                     end else begin
                        r_idx  <= r_idx + BEAT_W'(1);
                        r_addr <= w_next_addr;
                        r_lfsr <= lfsr_next(r_lfsr);
                     end
                  end
               end else if (refresh_req) begin
                  r_ret_state <= S_WR;
                  r_ref_ack   <= 1'b1;
                  r_state     <= S_REF;
               end else begin
                  r_valid <= 1'b1;
                  r_write <= 1'b1;
                  r_wdata <= w_pattern;
               end
            end
            S_RD: begin
               if (r_valid) begin
                  if (dram_ready) begin
                     r_valid <= 1'b0;
                     r_tmr   <= TMR_LOAD;
                     r_state <= S_RWAIT;
                  end
               end else if (refresh_req) begin
                  r_ret_state <= S_RD;
                  r_ref_ack   <= 1'b1;
                  r_state     <= S_REF;
               end else begin
                  r_valid <= 1'b1;
                  r_write <= 1'b0;
               end
            end
            S_RWAIT: begin
               if (dram_rdata_valid) begin
                  if (dram_rdata != w_pattern) begin
                     if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_W'(1);
                     if (!r_err_flag) begin
                        r_err_flag  <= 1'b1;
                        r_first_err <= r_addr;
                     end
                  end
                  if (w_last) begin
                     r_state <= S_DONE;
                  end else begin
                     r_idx   <= r_idx + BEAT_W'(1);
                     r_addr  <= w_next_addr;
                     r_lfsr  <= lfsr_next(r_lfsr);
                     r_state <= S_RD;
                  end
               end else if (r_tmr == '0) begin
                  r_timeout <= 1'b1;
                  r_state   <= S_DONE;
               end else begin
                  r_tmr <= r_tmr - TMR_W'(1);
               end
            end
            S_REF: if (!refresh_req) r_state <= r_ret_state;
            S_DONE: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy            = r_busy;
   assign done            = r_done;
   assign error_count     = r_err_cnt;
   assign first_err_addr  = r_first_err;
   assign err_flag        = r_err_flag;
   assign timeout_flag    = r_timeout;
   assign refresh_ack     = r_ref_ack;
   assign dram_address    = r_addr;
   assign dram_write      = r_write;
   assign dram_valid      = r_valid;
   assign dram_wdata      = r_wdata;
   assign dram_wdata_mask = '0;

endmodule

// File: tb/tb_dram_pattern_tester.sv
// Bench for dram_pattern_tester: memory model with scoreboard queues,
// a table of test runs and hand sequences for refresh, timeout and init.
module tb_dram_pattern_tester;
   localparam int          ADDR_W  = 27;
   localparam int          DATA_W  = 128;
   localparam int          BEAT_W  = 24;
   localparam int          ERR_W   = 16;
   localparam int          TIMEOUT = 1024;
   localparam logic [31:0] SEED    = 32'hACE1_2025;

   logic                 clk, reset_n, sdram_init_busy, start;
   logic [ADDR_W-1:0]    cfg_base;
   logic [BEAT_W-1:0]    cfg_beats;
   logic [1:0]           cfg_mode;
   logic                 busy, done, err_flag, timeout_flag;
   logic [ERR_W-1:0]     error_count;
   logic [ADDR_W-1:0]    first_err_addr;
   logic                 refresh_req, refresh_ack;
   logic [ADDR_W-1:0]    dram_address;
   logic                 dram_write, dram_valid, dram_ready;
   logic [DATA_W-1:0]    dram_wdata, dram_rdata;
   logic [DATA_W/8-1:0]  dram_wdata_mask;
   logic                 dram_rdata_valid;

   dram_pattern_tester #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEAT_W(BEAT_W), .ERR_W(ERR_W),
      .LFSR_SEED(SEED), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset_n(reset_n), .sdram_init_busy(sdram_init_busy), .start(start),
      .cfg_base(cfg_base), .cfg_beats(cfg_beats), .cfg_mode(cfg_mode),
      .busy(busy), .done(done), .error_count(error_count), .first_err_addr(first_err_addr),
      .err_flag(err_flag), .timeout_flag(timeout_flag),
      .refresh_req(refresh_req), .refresh_ack(refresh_ack),
      .dram_address(dram_address), .dram_write(dram_write), .dram_valid(dram_valid),
      .dram_ready(dram_ready), .dram_wdata(dram_wdata), .dram_wdata_mask(dram_wdata_mask),
      .dram_rdata(dram_rdata), .dram_rdata_valid(dram_rdata_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // reference pattern, LFSR recomputed from the seed for every beat
   function automatic logic [DATA_W-1:0] exp_pat(input logic [1:0] mode, input int i);
      logic [31:0]       l;
      logic [31:0]       v;
      logic [63:0]       rot;
      logic [DATA_W-1:0] p;
      l = SEED;
      for (int k = 0; k < i; k++) l = l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
      p = '0;
      for (int j = 0; j < DATA_W/32; j++) begin
         v   = 32'(i + j);
         rot = {l, l} << j;
         case (mode)
            2'd0:    p[j*32 +: 32] = v;
            2'd1:    p[j*32 +: 32] = ~v;
            2'd3:    p[j*32 +: 32] = rot[63:32];
            default: ;
         endcase
      end
      if (mode == 2'd2) p[i % DATA_W] = 1'b1;
      return p;
   endfunction

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   wr_t               wq[$];
   logic [ADDR_W-1:0] rq[$];
   logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];

   bit                ready_rand, ready_low, read_never, spurious, corrupt_en, corrupt_all;
   logic [ADDR_W-1:0] corrupt_addr;
   bit                rd_pend, hold_pend, h_wr;
   int                rd_cnt;
   logic [ADDR_W-1:0] rd_addr, h_addr;
   logic [DATA_W-1:0] h_data;
   time               rd_acc_time;

   task automatic push_expected(input logic [1:0] mode, input logic [ADDR_W-1:0] base, input int beats);
      logic [ADDR_W-1:0] a;
      wr_t e;
      a = base;
      for (int i = 0; i < beats; i++) begin
         e.addr = a;
         e.data = exp_pat(mode, i);
         wq.push_back(e);
         rq.push_back(a);
         a = a + ADDR_W'(8);
      end
   endtask

   // memory model: acts 1 time unit after each falling edge
   initial begin
      wr_t e;
      dram_ready = 1'b0; dram_rdata_valid = 1'b0; dram_rdata = '0;
      forever begin
         @(negedge clk); #1;
         dram_rdata_valid = 1'b0;
         if (rd_pend) begin
            if (!read_never) begin
               if (rd_cnt == 0) begin
                  dram_rdata = mem.exists(rd_addr) ? mem[rd_addr] : '0;
                  if (corrupt_all || (corrupt_en && rd_addr == corrupt_addr))
                     dram_rdata[3] = ~dram_rdata[3];
                  dram_rdata_valid = 1'b1;
                  rd_pend = 1'b0;
               end else begin
                  rd_cnt--;
               end
            end
         end else if (spurious && $urandom_range(0, 7) == 0) begin
            dram_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
            dram_rdata_valid = 1'b1;
         end
         if (hold_pend) begin
            check("req_hold_ctl", {dram_valid, dram_write, dram_address}, {1'b1, h_wr, h_addr});
            check("req_hold_data", dram_wdata, h_data);
         end
         dram_ready = ready_low ? 1'b0 : (ready_rand ? 1'($urandom_range(0, 1)) : 1'b1);
         hold_pend = 1'b0;
         if (dram_valid) begin
            if (dram_ready) begin
               if (dram_write) begin
                  if (wq.size() == 0) begin
                     n_checks++; n_fail++;
                     $display("FAIL unexpected_write: got addr %0h, expected no write", dram_address);
                  end else begin
                     e = wq.pop_front();
                     check("wr_addr", dram_address, e.addr);
                     check("wr_data", dram_wdata, e.data);
                  end
                  mem[dram_address] = dram_wdata;
               end else begin
                  if (rq.size() == 0) begin
                     n_checks++; n_fail++;
                     $display("FAIL unexpected_read: got addr %0h, expected no read", dram_address);
                  end else begin
                     check("rd_addr", dram_address, rq.pop_front());
                  end
                  check("single_outstanding", rd_pend, 1'b0);
                  rd_pend     = 1'b1;
                  rd_cnt      = $urandom_range(0, 3);
                  rd_addr     = dram_address;
                  rd_acc_time = $time + 4;
               end
            end else begin
               hold_pend = 1'b1;
               h_wr   = dram_write;
               h_addr = dram_address;
               h_data = dram_wdata;
            end
         end
      end
   end

   task automatic do_start(input logic [1:0] mode, input logic [ADDR_W-1:0] base, input int beats);
      cfg_mode = mode; cfg_base = base; cfg_beats = BEAT_W'(beats);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int bound);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < bound && !seen; c++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check({tag, "_done_seen"}, seen, 1'b1);
      if (seen) begin
         check({tag, "_busy_at_done"}, busy, 1'b0);
         @(negedge clk);
         check({tag, "_done_one_cycle"}, done, 1'b0);
      end
   endtask

   task automatic model_setup(input bit rnd, input bit spur);
      ready_rand = rnd; ready_low = 1'b0; read_never = 1'b0; spurious = spur;
      corrupt_en = 1'b0; corrupt_all = 1'b0; corrupt_addr = '0;
      rd_pend = 1'b0; wq.delete(); rq.delete(); mem.delete();
   endtask

   typedef struct {
      logic [1:0]        mode;
      logic [ADDR_W-1:0] base;
      int                beats;
      bit                c_en;
      bit                c_all;
      logic [ADDR_W-1:0] c_addr;
      int                exp_errs;
      logic [ADDR_W-1:0] exp_first;
      bit                exp_flag;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ack_cnt, val_cnt;
      bit seen;
      time t_flag;
      logic [DATA_W-1:0] m16;

      vecs[0] = '{mode:2'd0, base:27'h0,       beats:4,   c_en:0, c_all:0, c_addr:27'h0,
                  exp_errs:0,  exp_first:27'h0,    exp_flag:0};
      vecs[1] = '{mode:2'd2, base:27'h0,       beats:130, c_en:1, c_all:0, c_addr:27'h40,
                  exp_errs:1,  exp_first:27'h40,   exp_flag:1};
      vecs[2] = '{mode:2'd1, base:27'h7FFFFF8, beats:2,   c_en:0, c_all:0, c_addr:27'h0,
                  exp_errs:0,  exp_first:27'h0,    exp_flag:0};
      vecs[3] = '{mode:2'd3, base:27'h1000,    beats:20,  c_en:1, c_all:0, c_addr:27'h1028,
                  exp_errs:1,  exp_first:27'h1028, exp_flag:1};
      vecs[4] = '{mode:2'd1, base:27'h200,     beats:10,  c_en:0, c_all:1, c_addr:27'h0,
                  exp_errs:10, exp_first:27'h200,  exp_flag:1};
      vecs[5] = '{mode:2'd0, base:27'h500,     beats:0,   c_en:0, c_all:0, c_addr:27'h0,
                  exp_errs:0,  exp_first:27'h0,    exp_flag:0};

      reset_n = 1'b0; sdram_init_busy = 1'b0; start = 1'b0; refresh_req = 1'b0;
      cfg_base = '0; cfg_beats = '0; cfg_mode = '0;
      model_setup(1'b0, 1'b0);
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err_cnt", error_count, '0);
      check("rst_first_err", first_err_addr, '0);
      check("rst_flags", {err_flag, timeout_flag, refresh_ack}, 3'b000);
      check("rst_req", {dram_valid, dram_write, dram_address}, '0);
      check("rst_wdata", dram_wdata, '0);
      check("rst_mask", dram_wdata_mask, '0);
      reset_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         model_setup(1'b1, 1'b1);
         corrupt_en = vecs[i].c_en; corrupt_all = vecs[i].c_all; corrupt_addr = vecs[i].c_addr;
         push_expected(vecs[i].mode, vecs[i].base, vecs[i].beats);
         do_start(vecs[i].mode, vecs[i].base, vecs[i].beats);
         wait_done($sformatf("v%0d", i), 200 + vecs[i].beats * 40);
         check($sformatf("v%0d_err_cnt", i), error_count, ERR_W'(vecs[i].exp_errs));
         check($sformatf("v%0d_first_err", i), first_err_addr, vecs[i].exp_first);
         check($sformatf("v%0d_err_flag", i), err_flag, vecs[i].exp_flag);
         check($sformatf("v%0d_timeout", i), timeout_flag, 1'b0);
         check($sformatf("v%0d_queues_empty", i), wq.size() + rq.size(), 0);
         if (i == 0) begin
            m16 = mem.exists(27'd16) ? mem[27'd16] : '0;
            check("m0_beat2_lane0", m16[31:0], 32'h2);
            check("m0_beat2_lane3", m16[127:96], 32'h5);
         end
         if (i == 2) check("wrap_addr0_written", mem.exists(27'd0), 1'b1);
      end

      // refresh request while a write is held off by dram_ready=0
      model_setup(1'b0, 1'b0);
      ready_low = 1'b1;
      push_expected(2'd0, 27'h0, 4);
      do_start(2'd0, 27'h0, 4);
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(negedge clk);
         if (dram_valid) seen = 1'b1;
      end
      check("ref_first_valid", seen, 1'b1);
      refresh_req = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("ref_write_held", dram_valid, 1'b1);
         check("ref_no_early_ack", refresh_ack, 1'b0);
      end
      ready_low = 1'b0;
      ack_cnt = 0; val_cnt = 0;
      repeat (12) begin
         @(negedge clk);
         ack_cnt += int'(refresh_ack);
         val_cnt += int'(dram_valid);
      end
      check("ref_ack_once", ack_cnt, 1);
      check("ref_no_valid", val_cnt, 0);
      check("ref_write_accepted", wq.size(), 3);
      refresh_req = 1'b0;
      wait_done("ref", 400);
      check("ref_err_cnt", error_count, '0);
      check("ref_queues_empty", wq.size() + rq.size(), 0);

      // read data never returns
      model_setup(1'b0, 1'b0);
      read_never = 1'b1;
      push_expected(2'd0, 27'h300, 1);
      do_start(2'd0, 27'h300, 1);
      seen = 1'b0; t_flag = 0;
      for (int c = 0; c < 3000 && !seen; c++) begin
         @(negedge clk);
         if (timeout_flag) begin
            seen = 1'b1;
            t_flag = $time;
         end
      end
      check("to_flag_seen", seen, 1'b1);
      check("to_cycles_after_accept", (t_flag - 5 - rd_acc_time) / 10, TIMEOUT);
      wait_done("to", 10);
      check("to_flag_holds", timeout_flag, 1'b1);
      check("to_err_cnt", error_count, '0);
      check("to_read_issued", rq.size(), 0);

      // long init phase with stray start pulses during the run
      model_setup(1'b1, 1'b1);
      sdram_init_busy = 1'b1;
      push_expected(2'd3, 27'h100, 16);
      do_start(2'd3, 27'h100, 16);
      val_cnt = 0;
      cfg_mode = 2'd0; cfg_base = 27'h0; cfg_beats = BEAT_W'(5);
      for (int c = 0; c < 500; c++) begin
         start = (c == 250);
         @(negedge clk);
         val_cnt += int'(dram_valid);
      end
      start = 1'b0;
      check("init_no_valid", val_cnt, 0);
      check("init_busy", busy, 1'b1);
      sdram_init_busy = 1'b0;
      repeat (10) @(negedge clk);
      do_start(2'd1, 27'h40, 3);
      wait_done("init", 2000);
      check("init_err_cnt", error_count, '0);
      check("init_err_flag", err_flag, 1'b0);
      check("init_queues_empty", wq.size() + rq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/dram_pattern_tester.md
Name: dram_pattern_tester

Overview:
- Parametrised DDR3 memory test engine, the successor to the fixed test controller's DRAM path.
- Sits between the control/UART host logic and the DDR3 controller bus, in the controller clock domain.
- Writes a selectable data pattern over a configurable beat range, reads it back and compares each beat.
- Services controller refresh requests and reports error count, first failing address and timeout.

Parameters:
ADDR_W, 27, DRAM word address width (16-bit words)
DATA_W, 128, beat width; multiple of 32
BEAT_W, 24, width of beat-count config
ERR_W, 16, error counter width (saturating)
LFSR_SEED, 32'hACE1_2025, LFSR seed for mode 3
TIMEOUT, 1024, max cycles from read accept to rdata_valid

Ports:
clk  in  1  controller clock
reset_n  in  1  asynchronous active-low reset
sdram_init_busy  in  1  1 = DDR3 initialising
start  in  1  one-cycle start pulse
cfg_base  in  ADDR_W  first word address
cfg_beats  in  BEAT_W  number of beats to test
cfg_mode  in  2  pattern select
busy  out  1  test running
done  out  1  one-cycle pulse at completion
error_count  out  ERR_W  mismatching beats
first_err_addr  out  ADDR_W  address of first mismatch
err_flag  out  1  at least one mismatch
timeout_flag  out  1  read timeout occurred
refresh_req  in  1  refresh request from controller
refresh_ack  out  1  refresh grant pulse
dram_address  out  ADDR_W  request address
dram_write  out  1  1 = write, 0 = read
dram_valid  out  1  request valid
dram_ready  in  1  controller ready
dram_wdata  out  DATA_W  write data
dram_wdata_mask  out  DATA_W/8  byte mask, 1 = masked
dram_rdata  in  DATA_W  read data
dram_rdata_valid  in  1  read data valid

Behaviour:
- Reset values:
  - All outputs 0; dram_wdata_mask is constant all-zero.
  - The reset is asynchronous, active-low (reset_n).
- Address and step:
  - Beat i uses address cfg_base + i*(DATA_W/16), computed modulo 2^ADDR_W so that it wraps.
- Patterns: lane j is the 32-bit lane j of a beat; i is zero-extended to 32 bits.
  - Mode 0: lane j = i + j.
  - Mode 1: lane j = ~(i + j).
  - Mode 2: only bit (i mod DATA_W) is 1.
  - Mode 3: lane j = lfsr rotated left by j.
    - lfsr is a Galois LFSR with taps x^32+x^22+x^2+x+1.
    - It is loaded with LFSR_SEED at the start of each pass and advances after each accepted beat.
- Handshake:
  - A request transfers on a clock where dram_valid=1 and dram_ready=1.
  - While valid is high, address, write and wdata are held stable.
  - Valid is never withdrawn before it is accepted.
- States:
  - IDLE: a start pulse latches the cfg_* inputs, clears the flags, error_count and first_err_addr, and sets busy=1.
    - cfg_beats=0 goes directly to DONE.
    - Otherwise the next state is INIT.
  - INIT: waits while sdram_init_busy=1, then goes to WR.
  - WR: issues write beats 0..N-1. After the last accept it reloads the pattern generator and goes to RD.
  - RD: issues a read request. On accept it goes to RWAIT.
  - RWAIT:
    - On rdata_valid, compares rdata with the expected pattern.
      - On mismatch, error_count increments and saturates at 2^ERR_W-1.
      - On the first mismatch only, first_err_addr is captured and err_flag is set.
    - After the compare, the next state is RD, or DONE after the last beat.
    - If TIMEOUT cycles elapse without rdata_valid, timeout_flag=1 and the next state is DONE.
  - REF:
    - Entered from WR or RD when refresh_req=1 and no request is pending. A pending request completes first.
    - refresh_ack is pulsed for exactly one cycle.
    - The block then waits for refresh_req=0 and returns to the interrupted state.
  - DONE: done pulses for one cycle, busy goes to 0, the next state is IDLE, and the result outputs hold.
- Only one read is outstanding at a time.
- dram_rdata_valid outside RWAIT is ignored.
- start while busy=1 is ignored.
- Simultaneous refresh_req and request accept: the accept completes first, then REF is entered.

Test Plan:
- Mode 0, base 0, beats 4, ideal memory model → writes at addresses 0, 8, 16, 24; lane0 of beat 2 = 32'h2 and lane3 = 32'h5; done pulses with error_count=0.
- Mode 2, beats 130, model corrupts the beat at address 0x40 → error_count=1, first_err_addr=0x40, err_flag=1.
- Base 27'h7FFFFF8, beats 2 → the second address wraps to 0.
- refresh_req asserted while a write is held by dram_ready=0 → the write is accepted first, then refresh_ack pulses once; no valid is issued until refresh_req=0.
- Model never returns read data → timeout_flag=1 exactly TIMEOUT cycles after the read accept, and done pulses.
- sdram_init_busy=1 for 500 cycles, plus a second start pulse mid-test → no dram_valid until init ends; the second start is ignored and mode 3 completes with 0 errors.
